gray_ptr_counter: RTL and testbench

Parametrised up/down Gray-code pointer counter for async FIFO read/write pointers and clock-domain-crossing counters. Keeps a binary counter and its Gray image, both registered and always consistent in the same cycle. Adds direction control, synchronous clear, parallel load, a one-cycle wrap pulse and a combinational next-Gray output for full/empty look-ahead. Sits beside FIFO storage; the Gray output goes to a synchroniser in the other domain.

---
 rtl/gray_ptr_counter_pkg.sv | 31 +++
 rtl/gray_ptr_counter_if.sv | 25 ++
 rtl/gray_ptr_counter.sv | 71 +++++++
 tb/tb_gray_ptr_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ptr_counter_pkg.sv
// gray_pkg: shared Gray-code helpers and direction encoding
// for pointer counters and their receiving clock domains.
package gray_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Widest counter supported; callers cast to their own width.
    localparam int MAX_LEN = 32;

    function automatic logic [MAX_LEN-1:0] bin2gray(
        input logic [MAX_LEN-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB down; zero-extended inputs are safe.
    function automatic logic [MAX_LEN-1:0] gray2bin(
        input logic [MAX_LEN-1:0] g
    );
        logic [MAX_LEN-1:0] b;
        b[MAX_LEN-1] = g[MAX_LEN-1];
        for (int i = MAX_LEN - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_counter_if.sv
// gray_ptr_counter_if: control and count bundle for the
// Gray pointer counter; master drives controls, slave counts.
interface gray_ptr_counter_if #(
    parameter int ADDR_LEN = 4
);
    logic                en;
    logic                dir;
    logic                clr;
    logic                load;
    logic [ADDR_LEN-1:0] load_val;
    logic [ADDR_LEN-1:0] bin;
    logic [ADDR_LEN-1:0] gray;
    logic [ADDR_LEN-1:0] gray_next;
    logic                wrap;

    modport master (
        output en, dir, clr, load, load_val,
        input  bin, gray, gray_next, wrap
    );

    modport slave (
        input  en, dir, clr, load, load_val,
        output bin, gray, gray_next, wrap
    );
endinterface

// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter: up/down binary counter with a registered
// Gray image, wrap pulse and combinational next-Gray look-ahead.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int                  ADDR_LEN  = 4,
    parameter logic [ADDR_LEN-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               reset,
    gray_ptr_counter_if.slave bus
);

    localparam logic [ADDR_LEN-1:0] RST_GRAY =
        ADDR_LEN'(bin2gray(MAX_LEN'(RESET_VAL)));

    logic [ADDR_LEN-1:0] bin_q;
    logic [ADDR_LEN-1:0] gray_q;
    logic                wrap_q;

    logic [ADDR_LEN-1:0] step_bin;
    logic [ADDR_LEN-1:0] step_gray;
    logic [ADDR_LEN-1:0] load_gray;
    logic                step_wrap;
    dir_e                d;

    // Value one en-step away; feeds both the register and gray_next.
    always_comb begin
        d         = dir_e'(bus.dir);
        step_bin  = bin_q;
        step_wrap = 1'b0;
        if (d == DIR_UP) begin
            step_bin  = bin_q + ADDR_LEN'(1);
            step_wrap = (bin_q == '1);
        end else begin
            step_bin  = bin_q - ADDR_LEN'(1);
            step_wrap = (bin_q == '0);
        end
        step_gray = ADDR_LEN'(bin2gray(MAX_LEN'(step_bin)));
        load_gray = ADDR_LEN'(bin2gray(MAX_LEN'(bus.load_val)));
    end

    // Count register: clr > load > en > hold; wrap pulses one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q  <= RESET_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else if (bus.clr) begin
            bin_q  <= RESET_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            bin_q  <= bus.load_val;
            gray_q <= load_gray;
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            bin_q  <= step_bin;
            gray_q <= step_gray;
            wrap_q <= step_wrap;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.bin       = bin_q;
    assign bus.gray      = gray_q;
    assign bus.wrap      = wrap_q;
    assign bus.gray_next = step_gray;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// tb_gray_ptr_counter: scenario tasks plus randomized run
// checked against an integer-arithmetic reference model.
module tb_gray_ptr_counter;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;
    int   pass_cnt = 0;
    int   total    = 0;

    gray_ptr_counter_if #(.ADDR_LEN(4)) ia ();
    gray_ptr_counter_if #(.ADDR_LEN(4)) ib ();
    gray_ptr_counter_if #(.ADDR_LEN(2)) ic ();
    gray_ptr_counter_if #(.ADDR_LEN(8)) id ();

    gray_ptr_counter #(.ADDR_LEN(4), .RESET_VAL(4'd0)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia.slave));
    gray_ptr_counter #(.ADDR_LEN(4), .RESET_VAL(4'd5)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib.slave));
    gray_ptr_counter #(.ADDR_LEN(2), .RESET_VAL(2'd0)) dut_c (
        .clk(clk), .reset(rst_c), .bus(ic.slave));
    gray_ptr_counter #(.ADDR_LEN(8), .RESET_VAL(8'd0)) dut_d (
        .clk(clk), .reset(rst_d), .bus(id.slave));

    function automatic int g_of(input int b);
        return b ^ (b / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        #2;
        total++;
        if (ia.bin !== 4'd0 || ia.gray !== 4'd0 || ia.wrap !== 1'b0)
            $display("FAIL reset_a bin=%h gray=%h wrap=%b want 0 0 0",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
        total++;
        if (ib.bin !== 4'd5 || ib.gray !== 4'd7 || ib.wrap !== 1'b0)
            $display("FAIL reset_b bin=%h gray=%h wrap=%b want 5 7 0",
                     ib.bin, ib.gray, ib.wrap);
        else pass_cnt++;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] gtab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5,
            4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        int m = 0;
        ia.dir = 1'b1;
        ia.en  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            m = (m + 1) % 16;
            total++;
            if (ia.bin !== 4'(m) || ia.gray !== gtab[i] ||
                ia.wrap !== (m == 0))
                $display("FAIL count_up[%0d] bin=%h gray=%h wrap=%b want %h %h %b",
                         i, ia.bin, ia.gray, ia.wrap, m, gtab[i], m == 0);
            else pass_cnt++;
        end
        ia.en = 1'b0;
    endtask

    task automatic test_count_down();
        ia.dir = 1'b0;
        ia.en  = 1'b1;
        tick();
        total++;
        if (ia.bin !== 4'hF || ia.gray !== 4'h8 || ia.wrap !== 1'b1)
            $display("FAIL down_wrap bin=%h gray=%h wrap=%b want f 8 1",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
        tick();
        total++;
        if (ia.bin !== 4'hE || ia.gray !== 4'h9 || ia.wrap !== 1'b0)
            $display("FAIL down_step bin=%h gray=%h wrap=%b want e 9 0",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
        ia.en = 1'b0;
        tick();
        total++;
        if (ia.bin !== 4'hE || ia.gray !== 4'h9 || ia.wrap !== 1'b0)
            $display("FAIL hold bin=%h gray=%h wrap=%b want e 9 0",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        ia.load = 1'b1; ia.load_val = 4'h3;
        tick();
        total++;
        if (ia.bin !== 4'h3 || ia.gray !== 4'h2)
            $display("FAIL load3 bin=%h gray=%h want 3 2", ia.bin, ia.gray);
        else pass_cnt++;
        ia.clr = 1'b1; ia.load_val = 4'hA; ia.en = 1'b1; ia.dir = 1'b1;
        tick();
        total++;
        if (ia.bin !== 4'h0 || ia.gray !== 4'h0 || ia.wrap !== 1'b0)
            $display("FAIL clr_prio bin=%h gray=%h wrap=%b want 0 0 0",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
        ia.clr = 1'b0;
        tick();
        total++;
        if (ia.bin !== 4'hA || ia.gray !== 4'hF || ia.wrap !== 1'b0)
            $display("FAIL load_prio bin=%h gray=%h wrap=%b want a f 0",
                     ia.bin, ia.gray, ia.wrap);
        else pass_cnt++;
        ia.load_val = 4'hF; ia.en = 1'b0;
        tick();
        ia.load = 1'b0; ia.en = 1'b1; ia.dir = 1'b1;
        tick();
        total++;
        if (ia.bin !== 4'h0 || ia.wrap !== 1'b1)
            $display("FAIL load_then_wrap bin=%h wrap=%b want 0 1",
                     ia.bin, ia.wrap);
        else pass_cnt++;
        ia.en = 1'b0;
    endtask

    task automatic test_lookahead();
        ia.load = 1'b1; ia.load_val = 4'h7;
        tick();
        ia.load = 1'b0; ia.en = 1'b0; ia.dir = 1'b1;
        #1;
        total++;
        if (ia.gray_next !== 4'hC)
            $display("FAIL next_up gray_next=%h want c", ia.gray_next);
        else pass_cnt++;
        tick();
        total++;
        if (ia.bin !== 4'h7 || ia.gray !== 4'h4)
            $display("FAIL next_hold bin=%h gray=%h want 7 4",
                     ia.bin, ia.gray);
        else pass_cnt++;
        ia.dir = 1'b0;
        #1;
        total++;
        if (ia.gray_next !== 4'h5)
            $display("FAIL next_down gray_next=%h want 5", ia.gray_next);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        ib.dir = 1'b1; ib.en = 1'b1;
        repeat (4) tick();
        ib.en = 1'b0;
        total++;
        if (ib.bin !== 4'h9 || ib.gray !== 4'hD)
            $display("FAIL b_count bin=%h gray=%h want 9 d", ib.bin, ib.gray);
        else pass_cnt++;
        @(negedge clk);
        #1 rst_b = 1'b1;
        #1;
        total++;
        if (ib.bin !== 4'h5 || ib.gray !== 4'h7 || ib.wrap !== 1'b0)
            $display("FAIL async_rst bin=%h gray=%h wrap=%b want 5 7 0",
                     ib.bin, ib.gray, ib.wrap);
        else pass_cnt++;
        rst_b = 1'b0;
        ib.en = 1'b1; ib.dir = 1'b0;
        tick();
        ib.en = 1'b0; ib.clr = 1'b1;
        tick();
        ib.clr = 1'b0;
        total++;
        if (ib.bin !== 4'h5 || ib.gray !== 4'h7)
            $display("FAIL clr_rv bin=%h gray=%h want 5 7", ib.bin, ib.gray);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int mc = 0, md = 0;
        logic ec, dc, ed, dd;
        logic [1:0] pgc, nxc;
        logic [7:0] pgd, nxd;
        for (int i = 0; i < 10000; i++) begin
            ec = ($urandom_range(0, 3) != 0);
            ed = ($urandom_range(0, 3) != 0);
            dc = 1'($urandom);
            dd = 1'($urandom);
            ic.en = ec; ic.dir = dc;
            id.en = ed; id.dir = dd;
            #1;
            pgc = ic.gray; nxc = ic.gray_next;
            pgd = id.gray; nxd = id.gray_next;
            tick();
            total++;
            if (ic.wrap !== (ec && (dc ? mc == 3 : mc == 0)))
                $display("FAIL rnd_c_wrap[%0d] got %b", i, ic.wrap);
            else pass_cnt++;
            total++;
            if (id.wrap !== (ed && (dd ? md == 255 : md == 0)))
                $display("FAIL rnd_d_wrap[%0d] got %b", i, id.wrap);
            else pass_cnt++;
            if (ec) mc = dc ? (mc + 1) % 4 : (mc + 3) % 4;
            if (ed) md = dd ? (md + 1) % 256 : (md + 255) % 256;
            total++;
            if (ic.bin !== 2'(mc) || ic.gray !== 2'(g_of(mc)) ||
                gray2bin(32'(ic.gray)) !== 32'(mc))
                $display("FAIL rnd_c[%0d] bin=%h gray=%h want %h %h",
                         i, ic.bin, ic.gray, mc, g_of(mc));
            else pass_cnt++;
            total++;
            if (id.bin !== 8'(md) || id.gray !== 8'(g_of(md)) ||
                gray2bin(32'(id.gray)) !== 32'(md))
                $display("FAIL rnd_d[%0d] bin=%h gray=%h want %h %h",
                         i, id.bin, id.gray, md, g_of(md));
            else pass_cnt++;
            if (ec) begin
                total++;
                if ($countones(ic.gray ^ pgc) != 1 || ic.gray !== nxc)
                    $display("FAIL rnd_c_step[%0d] gray=%h prev=%h next=%h",
                             i, ic.gray, pgc, nxc);
                else pass_cnt++;
            end
            if (ed) begin
                total++;
                if ($countones(id.gray ^ pgd) != 1 || id.gray !== nxd)
                    $display("FAIL rnd_d_step[%0d] gray=%h prev=%h next=%h",
                             i, id.gray, pgd, nxd);
                else pass_cnt++;
            end
        end
        ic.en = 1'b0; id.en = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        ia.en = 0; ia.dir = 0; ia.clr = 0; ia.load = 0; ia.load_val = '0;
        ib.en = 0; ib.dir = 0; ib.clr = 0; ib.load = 0; ib.load_val = '0;
        ic.en = 0; ic.dir = 0; ic.clr = 0; ic.load = 0; ic.load_val = '0;
        id.en = 0; id.dir = 0; id.clr = 0; id.load = 0; id.load_val = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_priority();
        test_lookahead();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
